// File: rtl/rv_muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative mul/div unit.
// The stage drives the request and result-accept side; the unit answers with ready, valid, result and busy.
interface rv_muldiv_unit_if #(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      funct3;
    logic            op_32b;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output req_valid, funct3, op_32b, rs1, rs2, flush, rsp_ready,
        input  req_ready, rsp_valid, result, busy
    );

    modport slave (
        input  req_valid, funct3, op_32b, rs1, rs2, flush, rsp_ready,
        output req_ready, rsp_valid, result, busy
    );
endinterface

// File: rtl/rv_muldiv_unit.sv
// Iterative RV M-extension multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle on operand magnitudes, with a final sign fixup and RV64 word-form support.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request; ready unless flushed
// MUL    | shift-add iterations, then one cycle to latch the product
// DIV    | restoring-divide iterations, then one cycle to latch the result
// FIX    | special case (div by zero, overflow, illegal); result latched on the second cycle
// DONE   | result valid, held until the consumer takes it
module rv_muldiv_unit #(
    parameter int XLEN     = 64,
    parameter bit W_OPS_EN = 1'b1
) (
    input logic          clk_i,
    input logic          rst_i,
    rv_muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'(signed'(v));
    endfunction

    state_t            state_q, state_d;
    logic              accept;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q, mcand_q;
    logic [XLEN-1:0]   opa_q, rem_q, dvsr_q, fix_q, result_q;
    logic              w_q, hi_q, quo_sel_q, neg_q;

    logic [2:0]      f3;
    logic            w, is_div, a_sgn, b_sgn, a_neg, b_neg, illegal, div0, ovf, special;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_ext, fix_val;

    always_comb begin
        f3      = bus.funct3;
        w       = bus.op_32b;
        is_div  = f3[2];
        a_sgn   = f3[2] ? !f3[0] : (f3[1:0] == 2'b01 || f3[1:0] == 2'b10);
        b_sgn   = f3[2] ? !f3[0] : (f3[1:0] == 2'b01);
        if (w) begin
            a_ext = a_sgn ? sext32(bus.rs1[31:0]) : XLEN'(bus.rs1[31:0]);
            b_ext = b_sgn ? sext32(bus.rs2[31:0]) : XLEN'(bus.rs2[31:0]);
        end else begin
            a_ext = bus.rs1;
            b_ext = bus.rs2;
        end
        a_neg   = a_sgn && a_ext[XLEN-1];
        b_neg   = b_sgn && b_ext[XLEN-1];
        a_mag   = a_neg ? -a_ext : a_ext;
        b_mag   = b_neg ? -b_ext : b_ext;
        min_ext = w ? sext32(32'h8000_0000) : MIN_X;
        illegal = w && (!W_OPS_EN || (!f3[2] && f3[1:0] != 2'b00));
        div0    = is_div && (b_ext == '0);
        ovf     = is_div && !f3[0] && (a_ext == min_ext) && (b_ext == '1);
        special = illegal || div0 || ovf;
        if (illegal)
            fix_val = '0;
        else if (div0)
            fix_val = f3[1] ? a_ext : '1;
        else
            fix_val = f3[1] ? '0 : a_ext;
    end

    // Restoring-divide step: bring in the next dividend bit and try to subtract.
    logic [XLEN:0] trial;
    logic          take;
    assign trial = {rem_q, opa_q[XLEN-1]};
    assign take  = trial >= {1'b0, dvsr_q};

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   div_val, raw, fin;
    always_comb begin
        prod    = neg_q ? -acc_q : acc_q;
        div_val = quo_sel_q ? opa_q : rem_q;
        case (state_q)
            S_MUL:   raw = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
            S_DIV:   raw = neg_q ? -div_val : div_val;
            default: raw = fix_q;
        endcase
        fin = w_q ? sext32(raw[31:0]) : raw;
    end

    logic working, iter, finish;
    assign working = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    assign iter    = working && (cnt_q != '0);
    assign finish  = working && (cnt_q == '0) && !bus.flush;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid && !bus.flush) begin
                    accept  = 1'b1;
                    state_d = special ? S_FIX : (is_div ? S_DIV : S_MUL);
                end
            end
            S_MUL, S_DIV, S_FIX: begin
                if (cnt_q == '0)
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.rsp_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.flush)
            state_d = S_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            opa_q     <= '0;
            rem_q     <= '0;
            dvsr_q    <= '0;
            fix_q     <= '0;
            result_q  <= '0;
            w_q       <= 1'b0;
            hi_q      <= 1'b0;
            quo_sel_q <= 1'b0;
            neg_q     <= 1'b0;
        end else if (accept) begin
            // FIX waits one counted cycle so special results land on the same schedule slot as T+2.
            cnt_q     <= special ? CW'(1) : (w ? CW'(32) : CW'(XLEN));
            acc_q     <= '0;
            mcand_q   <= {{XLEN{1'b0}}, b_mag};
            opa_q     <= (is_div && w) ? (a_mag << (XLEN - 32)) : a_mag;
            rem_q     <= '0;
            dvsr_q    <= b_mag;
            fix_q     <= fix_val;
            w_q       <= w;
            hi_q      <= !f3[2] && (f3[1:0] != 2'b00);
            quo_sel_q <= !f3[1];
            neg_q     <= (f3[2] && f3[1]) ? a_neg : (a_neg ^ b_neg);
        end else if (iter) begin
            cnt_q <= cnt_q - 1'b1;
            if (state_q == S_MUL) begin
                if (opa_q[0])
                    acc_q <= acc_q + mcand_q;
                mcand_q <= mcand_q << 1;
                opa_q   <= opa_q >> 1;
            end else if (state_q == S_DIV) begin
                rem_q <= take ? (trial[XLEN-1:0] - dvsr_q) : trial[XLEN-1:0];
                opa_q <= {opa_q[XLEN-2:0], take};
            end
        end else if (finish) begin
            result_q <= fin;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE) && !bus.flush;
    assign bus.rsp_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Randomized bench for rv_muldiv_unit (XLEN=64, word forms enabled) against an arithmetic reference model.
module tb_rv_muldiv_unit;
    localparam int XLEN = 64;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    rv_muldiv_unit_if #(.XLEN(XLEN)) bus ();

    rv_muldiv_unit #(.XLEN(XLEN), .W_OPS_EN(1'b1)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] ref_model(input logic [2:0] f3, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
        int              sx, sy;
        int unsigned     ux, uy;
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [31:0]     r32;
        logic [127:0]    p;
        sx = a[31:0]; sy = b[31:0]; ux = a[31:0]; uy = b[31:0];
        sa = a; sb = b; ua = a; ub = b;
        r32 = '0;
        if (w) begin
            if (f3 inside {3'd1, 3'd2, 3'd3}) return 64'd0;
            case (f3)
                3'd0: r32 = a[31:0] * b[31:0];
                3'd4: if (sy == 0) r32 = 32'hFFFF_FFFF;
                      else if (a[31:0] == 32'h8000_0000 && sy == -1) r32 = a[31:0];
                      else r32 = sx / sy;
                3'd5: if (uy == 0) r32 = 32'hFFFF_FFFF; else r32 = ux / uy;
                3'd6: if (sy == 0) r32 = a[31:0];
                      else if (a[31:0] == 32'h8000_0000 && sy == -1) r32 = 32'd0;
                      else r32 = sx % sy;
                default: if (uy == 0) r32 = a[31:0]; else r32 = ux % uy;
            endcase
            return {{32{r32[31]}}, r32};
        end
        case (f3)
            3'd0: return a * b;
            3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; return p[127:64]; end
            3'd3: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
            3'd4: begin
                if (sb == 0) return '1;
                if (a == 64'h8000_0000_0000_0000 && sb == -1) return a;
                return sa / sb;
            end
            3'd5: begin if (ub == 0) return '1; return ua / ub; end
            3'd6: begin
                if (sb == 0) return a;
                if (a == 64'h8000_0000_0000_0000 && sb == -1) return 64'd0;
                return sa % sb;
            end
            default: begin if (ub == 0) return a; return ua % ub; end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic w,
                                      input logic [63:0] a, input logic [63:0] b);
        if (w && (f3 inside {3'd1, 3'd2, 3'd3})) return 1'b1;
        if (!f3[2]) return 1'b0;
        if (w) return (b[31:0] == 0) ||
                      (!f3[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 0) || (!f3[0] && a == 64'h8000_0000_0000_0000 && b == '1);
    endfunction

    task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input int hold);
        logic [63:0] exp;
        int          exp_lat, k;
        exp     = ref_model(f3, w, a, b);
        exp_lat = is_special(f3, w, a, b) ? 2 : (w ? 33 : 65);
        @(negedge clk_i);
        chk("ready_before_req", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1; bus.funct3 = f3; bus.op_32b = w;
        bus.rs1 = a; bus.rs2 = b; bus.rsp_ready = (hold == 0);
        @(posedge clk_i);
        #1 bus.req_valid = 1'b0;
        k = 0;
        do begin
            @(posedge clk_i); k++;
            @(negedge clk_i);
        end while (!bus.rsp_valid && k < 200);
        chk($sformatf("latency f3=%0d w=%0d", f3, w), 64'(k), 64'(exp_lat));
        chk($sformatf("result f3=%0d w=%0d a=%h b=%h", f3, w, a, b), bus.result, exp);
        if (hold > 0) begin
            repeat (hold) begin @(posedge clk_i); @(negedge clk_i); end
            chk("hold_result", bus.result, exp);
            chk("hold_valid", bus.rsp_valid, 1'b1);
            chk("hold_ready_o", bus.req_ready, 1'b0);
            bus.rsp_ready = 1'b1;
        end
        @(posedge clk_i); @(negedge clk_i);
        chk("idle_after_take", {bus.busy, bus.rsp_valid}, 2'b00);
    endtask

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'hFFFF_FFFF_8000_0000;
            4: return 64'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        bit seen;
        bus.req_valid = 1'b0; bus.funct3 = '0; bus.op_32b = 1'b0;
        bus.rs1 = '0; bus.rs2 = '0; bus.flush = 1'b0; bus.rsp_ready = 1'b1;
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("rst_ready", bus.req_ready, 1'b1);
        chk("rst_valid", bus.rsp_valid, 1'b0);
        chk("rst_result", bus.result, 64'd0);
        chk("rst_busy", bus.busy, 1'b0);

        run_op(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op(3'd3, 1'b0, '1, '1, 0);
        run_op(3'd2, 1'b0, '1, 64'd2, 0);
        run_op(3'd4, 1'b0, 64'h1234, 64'd0, 0);
        run_op(3'd6, 1'b0, 64'h1234, 64'd0, 0);
        run_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 0);
        run_op(3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 0);
        run_op(3'd4, 1'b1, 64'hDEAD_BEEF_FFFF_FFF9, 64'd2, 0);
        run_op(3'd6, 1'b1, 64'hDEAD_BEEF_FFFF_FFF9, 64'd2, 0);
        run_op(3'd5, 1'b1, 64'h8000_0000, 64'd1, 0);
        run_op(3'd1, 1'b1, 64'd5, 64'd3, 0);
        run_op(3'd7, 1'b1, 64'h1_0000_0005, 64'h0, 0);
        run_op(3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5);
        run_op(3'd5, 1'b0, 64'd100, 64'd7, 0);

        // Flush ten cycles into a divide: the result must never appear.
        @(negedge clk_i);
        bus.req_valid = 1'b1; bus.funct3 = 3'd4; bus.op_32b = 1'b0;
        bus.rs1 = 64'd1000; bus.rs2 = 64'd3; bus.rsp_ready = 1'b1;
        @(posedge clk_i);
        #1 bus.req_valid = 1'b0;
        repeat (10) @(posedge clk_i);
        @(negedge clk_i) bus.flush = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("flush_busy", bus.busy, 1'b0);
        chk("flush_ready_masked", bus.req_ready, 1'b0);
        bus.flush = 1'b0;
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk_i);
            if (bus.rsp_valid) seen = 1'b1;
        end
        chk("flush_no_valid", seen, 1'b0);

        // Request together with flush in IDLE is not accepted.
        @(negedge clk_i);
        bus.req_valid = 1'b1; bus.flush = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        bus.req_valid = 1'b0; bus.flush = 1'b0;
        chk("flush_blocks_accept", bus.busy, 1'b0);

        // Reset in the middle of a multiply.
        @(negedge clk_i);
        bus.req_valid = 1'b1; bus.funct3 = 3'd0; bus.op_32b = 1'b0;
        bus.rs1 = 64'd12345; bus.rs2 = 64'd678;
        @(posedge clk_i);
        #1 bus.req_valid = 1'b0;
        repeat (20) @(posedge clk_i);
        @(negedge clk_i) rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("midrst_valid", bus.rsp_valid, 1'b0);
        chk("midrst_result", bus.result, 64'd0);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_ready", bus.req_ready, 1'b1);
        run_op(3'd0, 1'b0, 64'd12345, 64'd678, 0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic        w;
            logic [63:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            w  = ($urandom_range(0, 2) == 0);
            a  = pick_operand();
            b  = pick_operand();
            run_op(f3, w, a, b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
